rename_alloc: RTL and testbench

RENAME_ALLOC -- requirements
Module: rename_alloc

---
 rtl/rename_alloc.sv | 220 ++++++++++++++++++++++
 tb/tb_rename_alloc.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_alloc.sv
// Register-rename allocation stage.
//
// Takes a decoded group of up to RENAME_WIDTH lanes, reads the external RAT for
// each lane's sources and destination, pops fresh physical registers from a
// circular free list for every lane that writes a non-zero architectural
// register, resolves intra-group dependencies (sources and old mappings that
// refer to an earlier lane's destination), writes the RAT and presents the
// renamed group on a registered valid/ready output.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   in_valid / in_ready      decoded group handshake (all-or-nothing accept)
//   in_src_areg, in_dst_areg source / destination architectural registers
//   in_dst_vld, in_lane_vld  lane writes a register / lane occupied
//   rat_areg_in              RAT read addresses per lane: src0, src1, dst
//   rat_preg_alias_out       RAT read data, combinational from rat_areg_in
//   rat_w_en, rat_w_dst_areg, rat_w_new_alias
//                            RAT write port per lane
//   free_vld, free_preg      physical registers released by retire
//   out_valid / out_ready    handshake to dispatch
//   out_*                    registered renamed group
//   fl_count                 free-list occupancy
module rename_alloc #(
  parameter int unsigned RENAME_WIDTH = 2,
  parameter int unsigned NUM_AREGS    = 32,
  parameter int unsigned NUM_PREGS    = 64,
  localparam int unsigned FL_DEPTH    = NUM_PREGS - NUM_AREGS,
  localparam int unsigned AW          = $clog2(NUM_AREGS),
  localparam int unsigned PW          = $clog2(NUM_PREGS),
  localparam int unsigned CW          = $clog2(FL_DEPTH) + 1,
  localparam int unsigned W           = RENAME_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0][1:0][AW-1:0]    in_src_areg,
  input  logic [W-1:0][AW-1:0]         in_dst_areg,
  input  logic [W-1:0]                 in_dst_vld,
  input  logic [W-1:0]                 in_lane_vld,

  output logic [W-1:0][2:0][AW-1:0]    rat_areg_in,
  input  logic [W-1:0][2:0][PW-1:0]    rat_preg_alias_out,
  output logic [W-1:0]                 rat_w_en,
  output logic [W-1:0][AW-1:0]         rat_w_dst_areg,
  output logic [W-1:0][PW-1:0]         rat_w_new_alias,

  input  logic [W-1:0]                 free_vld,
  input  logic [W-1:0][PW-1:0]         free_preg,

  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0][1:0][PW-1:0]    out_src_preg,
  output logic [W-1:0][PW-1:0]         out_dst_preg,
  output logic [W-1:0][PW-1:0]         out_old_preg,
  output logic [W-1:0]                 out_dst_vld,
  output logic [W-1:0]                 out_lane_vld,

  output logic [CW-1:0]                fl_count
);

  localparam int unsigned PTRW = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

  // Circular free list.
  logic [PW-1:0]   fl_mem [FL_DEPTH];
  logic [PTRW-1:0] head_q;
  logic [PTRW-1:0] tail_q;
  logic [CW-1:0]   count_q;

  logic [W-1:0]          alloc;
  logic [W-1:0][PW-1:0]  new_preg;
  logic [CW-1:0]         need;
  logic [W-1:0][PTRW-1:0] push_idx;
  logic [CW-1:0]         push_cnt;
  logic [CW-1:0]         pop_cnt;
  logic                  accept;

  logic [W-1:0][1:0][PW-1:0] src_preg;
  logic [W-1:0][PW-1:0]      old_preg;

  // Pointer advance modulo FL_DEPTH (depth need not be a power of two).
  function automatic logic [PTRW-1:0] ptr_add(input logic [PTRW-1:0] p, input int unsigned ofs);
    int unsigned s;
    s = (32'(p) + ofs) % FL_DEPTH;
    return PTRW'(s);
  endfunction

  assign fl_count = count_q;

  // RAT read addresses: src0, src1, dst.
  always_comb begin
    for (int k = 0; k < W; k++) begin
      rat_areg_in[k][0] = in_src_areg[k][0];
      rat_areg_in[k][1] = in_src_areg[k][1];
      rat_areg_in[k][2] = in_dst_areg[k];
    end
  end

  // Allocation: lanes writing a non-zero areg take pregs from head in lane order.
  always_comb begin
    int unsigned n_alloc;
    n_alloc = 0;
    for (int k = 0; k < W; k++) begin
      alloc[k]    = in_lane_vld[k] && in_dst_vld[k] && (in_dst_areg[k] != '0);
      new_preg[k] = '0;
      if (alloc[k]) begin
        new_preg[k] = fl_mem[ptr_add(head_q, n_alloc)];
        n_alloc     = n_alloc + 1;
      end
    end
    need = CW'(n_alloc);
  end

  // Freed pregs land at tail in lane order.
  always_comb begin
    int unsigned n_push;
    n_push = 0;
    for (int k = 0; k < W; k++) begin
      push_idx[k] = ptr_add(tail_q, n_push);
      if (free_vld[k]) begin
        n_push = n_push + 1;
      end
    end
    push_cnt = CW'(n_push);
  end

  // Reset is folded in so nothing is accepted (and the RAT is not written)
  // during a reset cycle.
  assign in_ready = !rst && (!out_valid || out_ready) && (count_q >= need);
  assign accept   = in_valid && in_ready;
  assign pop_cnt  = accept ? need : '0;

  // Intra-group bypass: a later lane sees the newest mapping from earlier lanes.
  always_comb begin
    for (int k = 0; k < W; k++) begin
      for (int s = 0; s < 2; s++) begin
        src_preg[k][s] = rat_preg_alias_out[k][s];
        for (int j = 0; j < k; j++) begin
          if (alloc[j] && (in_dst_areg[j] == in_src_areg[k][s])) begin
            src_preg[k][s] = new_preg[j];
          end
        end
        // areg 0 is hardwired to preg 0; empty lanes carry no sources.
        if (in_src_areg[k][s] == '0 || !in_lane_vld[k]) begin
          src_preg[k][s] = '0;
        end
      end

      old_preg[k] = '0;
      if (alloc[k]) begin
        old_preg[k] = rat_preg_alias_out[k][2];
        for (int j = 0; j < k; j++) begin
          if (alloc[j] && (in_dst_areg[j] == in_dst_areg[k])) begin
            old_preg[k] = new_preg[j];
          end
        end
      end
    end
  end

  // RAT write: only the youngest lane targeting a given areg writes it.
  always_comb begin
    for (int k = 0; k < W; k++) begin
      logic youngest;
      youngest = 1'b1;
      for (int j = k + 1; j < W; j++) begin
        if (alloc[j] && (in_dst_areg[j] == in_dst_areg[k])) begin
          youngest = 1'b0;
        end
      end
      rat_w_en[k]        = accept && alloc[k] && youngest;
      rat_w_dst_areg[k]  = in_dst_areg[k];
      rat_w_new_alias[k] = new_preg[k];
    end
  end

  // Free-list state.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CW'(FL_DEPTH);
      for (int i = 0; i < int'(FL_DEPTH); i++) begin
        fl_mem[i] <= PW'(NUM_AREGS + i);
      end
    end else begin
      head_q  <= ptr_add(head_q, 32'(pop_cnt));
      tail_q  <= ptr_add(tail_q, 32'(push_cnt));
      count_q <= count_q - pop_cnt + push_cnt;
      for (int k = 0; k < W; k++) begin
        if (free_vld[k]) begin
          fl_mem[push_idx[k]] <= free_preg[k];
        end
      end
    end
  end

  // Output register: loads on accept, holds while dispatch stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_src_preg <= '0;
      out_dst_preg <= '0;
      out_old_preg <= '0;
      out_dst_vld  <= '0;
      out_lane_vld <= '0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_src_preg <= src_preg;
      out_dst_preg <= new_preg;
      out_old_preg <= old_preg;
      out_dst_vld  <= in_dst_vld;
      out_lane_vld <= in_lane_vld;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rename_alloc.sv
module tb_rename_alloc;

  localparam int W   = 2;
  localparam int AW  = 5;
  localparam int PW  = 6;
  localparam int NA  = 32;
  localparam int FLD = 32;
  localparam int CW  = 6;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       in_valid;
  logic                       in_ready;
  logic [W-1:0][1:0][AW-1:0]  in_src_areg;
  logic [W-1:0][AW-1:0]       in_dst_areg;
  logic [W-1:0]               in_dst_vld;
  logic [W-1:0]               in_lane_vld;
  logic [W-1:0][2:0][AW-1:0]  rat_areg_in;
  logic [W-1:0][2:0][PW-1:0]  rat_preg_alias_out;
  logic [W-1:0]               rat_w_en;
  logic [W-1:0][AW-1:0]       rat_w_dst_areg;
  logic [W-1:0][PW-1:0]       rat_w_new_alias;
  logic [W-1:0]               free_vld;
  logic [W-1:0][PW-1:0]       free_preg;
  logic                       out_valid;
  logic                       out_ready;
  logic [W-1:0][1:0][PW-1:0]  out_src_preg;
  logic [W-1:0][PW-1:0]       out_dst_preg;
  logic [W-1:0][PW-1:0]       out_old_preg;
  logic [W-1:0]               out_dst_vld;
  logic [W-1:0]               out_lane_vld;
  logic [CW-1:0]              fl_count;

  rename_alloc dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_src_areg        (in_src_areg),
    .in_dst_areg        (in_dst_areg),
    .in_dst_vld         (in_dst_vld),
    .in_lane_vld        (in_lane_vld),
    .rat_areg_in        (rat_areg_in),
    .rat_preg_alias_out (rat_preg_alias_out),
    .rat_w_en           (rat_w_en),
    .rat_w_dst_areg     (rat_w_dst_areg),
    .rat_w_new_alias    (rat_w_new_alias),
    .free_vld           (free_vld),
    .free_preg          (free_preg),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_src_preg       (out_src_preg),
    .out_dst_preg       (out_dst_preg),
    .out_old_preg       (out_old_preg),
    .out_dst_vld        (out_dst_vld),
    .out_lane_vld       (out_lane_vld),
    .fl_count           (fl_count)
  );

  always #5 clk = ~clk;

  // Environment RAT: identity at reset, written by the DUT.
  logic [PW-1:0] rat [NA];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NA; i++) rat[i] <= PW'(i);
    end else begin
      for (int k = 0; k < W; k++) begin
        if (rat_w_en[k]) rat[rat_w_dst_areg[k]] <= rat_w_new_alias[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < W; k++) begin
      for (int p = 0; p < 3; p++) rat_preg_alias_out[k][p] = rat[rat_areg_in[k][p]];
    end
  end

  typedef struct packed {
    logic [W-1:0][1:0][PW-1:0] src;
    logic [W-1:0][PW-1:0]      dst;
    logic [W-1:0][PW-1:0]      old;
    logic [W-1:0]              dvld;
    logic [W-1:0]              lvld;
  } exp_t;

  exp_t          sb [$];
  logic          mov;
  logic [PW-1:0] fl_q [$];
  logic [PW-1:0] rat_m [NA];
  int            checks = 0;
  int            errors = 0;

  task automatic model_reset();
    mov = 1'b0;
    fl_q.delete();
    for (int i = 0; i < FLD; i++) fl_q.push_back(PW'(NA + i));
    sb.delete();
    for (int i = 0; i < NA; i++) rat_m[i] = PW'(i);
  endtask

  task automatic clear_in();
    in_valid    = 1'b0;
    in_src_areg = '0;
    in_dst_areg = '0;
    in_dst_vld  = '0;
    in_lane_vld = '0;
    free_vld    = '0;
    free_preg   = '0;
  endtask

  task automatic set_lane(input int k, input logic lv, input logic dv, input int d,
                          input int s0, input int s1);
    in_lane_vld[k]    = lv;
    in_dst_vld[k]     = dv;
    in_dst_areg[k]    = AW'(d);
    in_src_areg[k][0] = AW'(s0);
    in_src_areg[k][1] = AW'(s1);
  endtask

  // One clock: scoreboard pop, model of accept/RAT write, model update, post-edge checks.
  task automatic step();
    exp_t                 e;
    logic [W-1:0]         al;
    logic [W-1:0]         ewen;
    logic [W-1:0][PW-1:0] nw;
    logic [PW-1:0]        v;
    logic                 exp_rdy;
    logic                 acc;
    logic                 yng;
    int                   n;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: out_valid=1 but required no pending beat");
      end else begin
        e = sb.pop_front();
        if (out_lane_vld !== e.lvld || out_dst_vld !== e.dvld || out_dst_preg !== e.dst ||
            out_old_preg !== e.old) begin
          errors++;
          $display("FAIL sb_beat: got lv=%b dv=%b dst=%h old=%h required lv=%b dv=%b dst=%h old=%h",
                   out_lane_vld, out_dst_vld, out_dst_preg, out_old_preg,
                   e.lvld, e.dvld, e.dst, e.old);
        end
        for (int k = 0; k < W; k++) begin
          if (e.lvld[k]) begin
            checks++;
            if (out_src_preg[k] !== e.src[k]) begin
              errors++;
              $display("FAIL sb_src lane%0d: got %h required %h", k, out_src_preg[k], e.src[k]);
            end
          end
        end
      end
    end

    n = 0;
    for (int k = 0; k < W; k++) begin
      al[k] = in_lane_vld[k] && in_dst_vld[k] && (in_dst_areg[k] != 0);
      nw[k] = '0;
      if (al[k]) begin
        if (n < fl_q.size()) nw[k] = fl_q[n];
        n++;
      end
    end
    exp_rdy = (!mov || out_ready) && (fl_q.size() >= n);
    if (!rst) begin
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL in_ready: got %b required %b", in_ready, exp_rdy);
      end
    end
    acc = !rst && in_valid && exp_rdy;

    e = '0;
    for (int k = 0; k < W; k++) begin
      for (int s = 0; s < 2; s++) begin
        v = (in_src_areg[k][s] == 0) ? '0 : rat_m[in_src_areg[k][s]];
        for (int j = 0; j < k; j++) begin
          if (al[j] && in_dst_areg[j] == in_src_areg[k][s]) v = nw[j];
        end
        e.src[k][s] = v;
      end
      v = '0;
      if (al[k]) begin
        v = rat_m[in_dst_areg[k]];
        for (int j = 0; j < k; j++) begin
          if (al[j] && in_dst_areg[j] == in_dst_areg[k]) v = nw[j];
        end
      end
      e.old[k] = v;
      e.dst[k] = nw[k];
      yng = 1'b1;
      for (int j = k + 1; j < W; j++) begin
        if (al[j] && in_dst_areg[j] == in_dst_areg[k]) yng = 1'b0;
      end
      ewen[k] = acc && al[k] && yng;
    end
    e.dvld = in_dst_vld;
    e.lvld = in_lane_vld;

    checks++;
    if (rat_w_en !== ewen) begin
      errors++;
      $display("FAIL rat_w_en: got %b required %b", rat_w_en, ewen);
    end
    for (int k = 0; k < W; k++) begin
      if (ewen[k]) begin
        checks++;
        if (rat_w_new_alias[k] !== nw[k] || rat_w_dst_areg[k] !== in_dst_areg[k]) begin
          errors++;
          $display("FAIL rat_write lane%0d: got a%0d->p%0d required a%0d->p%0d", k,
                   rat_w_dst_areg[k], rat_w_new_alias[k], in_dst_areg[k], nw[k]);
        end
      end
    end

    if (rst) begin
      model_reset();
    end else begin
      if (acc) begin
        sb.push_back(e);
        for (int i = 0; i < n; i++) void'(fl_q.pop_front());
        for (int k = 0; k < W; k++) if (al[k]) rat_m[in_dst_areg[k]] = nw[k];
        mov = 1'b1;
      end else if (out_ready) begin
        mov = 1'b0;
      end
      for (int k = 0; k < W; k++) begin
        if (free_vld[k]) begin
          checks++;
          if (fl_q.size() >= FLD) begin
            errors++;
            $display("FAIL push_full: free list holds %0d, required below %0d", fl_q.size(), FLD);
          end else begin
            fl_q.push_back(free_preg[k]);
          end
        end
      end
    end

    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== mov) begin
      errors++;
      $display("FAIL out_valid: got %b required %b", out_valid, mov);
    end
    checks++;
    if (fl_count !== CW'(fl_q.size())) begin
      errors++;
      $display("FAIL fl_count: got %0d required %0d", fl_count, fl_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    clear_in();
    in_valid = 1'b1;
    set_lane(0, 1'b1, 1'b1, 3, 1, 2);
    step();
    step();
    rst = 1'b0;
    clear_in();
    #1;
    checks++;
    if (out_valid !== 1'b0 || {out_src_preg, out_dst_preg, out_old_preg, out_dst_vld,
                               out_lane_vld} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b dst=%h old=%h required all zero",
               out_valid, out_dst_preg, out_old_preg);
    end
    checks++;
    if (fl_count !== CW'(32) || in_ready !== 1'b1 || rat_w_en !== '0) begin
      errors++;
      $display("FAIL reset_state: got count=%0d rdy=%b wen=%b required 32 1 00",
               fl_count, in_ready, rat_w_en);
    end
  endtask

  task automatic test_basic();
    in_valid = 1'b1;
    set_lane(0, 1'b1, 1'b1, 5, 1, 2);
    set_lane(1, 1'b1, 1'b1, 6, 5, 3);
    step();
    clear_in();
    checks++;
    if (out_dst_preg[0] !== 6'd32 || out_old_preg[0] !== 6'd5 || out_src_preg[0][0] !== 6'd1 ||
        out_src_preg[0][1] !== 6'd2) begin
      errors++;
      $display("FAIL basic_lane0: got dst=%0d old=%0d src=%0d,%0d required 32 5 1,2",
               out_dst_preg[0], out_old_preg[0], out_src_preg[0][0], out_src_preg[0][1]);
    end
    checks++;
    if (out_dst_preg[1] !== 6'd33 || out_old_preg[1] !== 6'd6 || out_src_preg[1][0] !== 6'd32 ||
        out_src_preg[1][1] !== 6'd3 || fl_count !== CW'(30)) begin
      errors++;
      $display("FAIL basic_lane1: got dst=%0d old=%0d src=%0d,%0d cnt=%0d required 33 6 32,3 30",
               out_dst_preg[1], out_old_preg[1], out_src_preg[1][0], out_src_preg[1][1], fl_count);
    end
  endtask

  task automatic test_same_dst();
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    set_lane(0, 1'b1, 1'b1, 7, 1, 2);
    set_lane(1, 1'b1, 1'b1, 7, 3, 4);
    #1;
    checks++;
    if (rat_w_en !== 2'b10 || rat_w_new_alias[1] !== 6'd33) begin
      errors++;
      $display("FAIL same_dst_wen: got wen=%b alias=%0d required 10 33", rat_w_en,
               rat_w_new_alias[1]);
    end
    step();
    clear_in();
    checks++;
    if (out_old_preg[1] !== 6'd32 || out_old_preg[0] !== 6'd7) begin
      errors++;
      $display("FAIL same_dst_old: got old0=%0d old1=%0d required 7 32", out_old_preg[0],
               out_old_preg[1]);
    end
  endtask

  task automatic test_zero_areg();
    in_valid = 1'b1;
    set_lane(0, 1'b1, 1'b1, 0, 0, 0);
    set_lane(1, 1'b0, 1'b0, 0, 0, 0);
    #1;
    checks++;
    if (rat_w_en !== '0) begin
      errors++;
      $display("FAIL zero_wen: got %b required 00", rat_w_en);
    end
    step();
    clear_in();
    checks++;
    if (out_valid !== 1'b1 || out_src_preg[0] !== '0 || out_dst_preg[0] !== '0 ||
        out_old_preg[0] !== '0 || fl_count !== CW'(30)) begin
      errors++;
      $display("FAIL zero_areg: got v=%b src=%h dst=%0d old=%0d cnt=%0d required 1 0 0 0 30",
               out_valid, out_src_preg[0], out_dst_preg[0], out_old_preg[0], fl_count);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_lane(0, 1'b1, 1'b1, 8, 7, 0);
    set_lane(1, 1'b1, 1'b1, 9, 8, 1);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_ready: got %b required 0", in_ready);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (in_ready !== 1'b0 || rat_w_en !== '0 || out_valid !== 1'b1 ||
          out_lane_vld !== 2'b01 || out_dst_vld !== 2'b01 || out_dst_preg !== '0 ||
          out_old_preg !== '0 || out_src_preg[0] !== '0) begin
        errors++;
        $display("FAIL stall_hold c%0d: got rdy=%b wen=%b v=%b lv=%b dst=%h required 0 00 1 01 0",
                 c, in_ready, rat_w_en, out_valid, out_lane_vld, out_dst_preg);
      end
    end
    out_ready = 1'b1;
    step();
    clear_in();
    checks++;
    if (out_dst_preg[0] !== 6'd34 || out_dst_preg[1] !== 6'd35 || out_src_preg[1][0] !== 6'd34 ||
        out_src_preg[0][0] !== 6'd33) begin
      errors++;
      $display("FAIL stall_release: got dst=%0d,%0d src=%0d,%0d required 34,35 33,34",
               out_dst_preg[0], out_dst_preg[1], out_src_preg[0][0], out_src_preg[1][0]);
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 15; i++) begin
      set_lane(0, 1'b1, 1'b1, $urandom_range(1, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      set_lane(1, 1'b1, 1'b1, $urandom_range(1, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      step();
    end
    set_lane(0, 1'b1, 1'b1, 12, 4, 5);
    set_lane(1, 1'b0, 1'b0, 0, 0, 0);
    step();
    set_lane(0, 1'b1, 1'b1, 10, 1, 2);
    set_lane(1, 1'b1, 1'b1, 11, 10, 3);
    #1;
    checks++;
    if (fl_count !== CW'(1) || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL wrap_low: got cnt=%0d rdy=%b required 1 0", fl_count, in_ready);
    end
    step();
    free_vld[0]  = 1'b1;
    free_preg[0] = 6'd9;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL wrap_free_same_cycle: got rdy=%b required 0", in_ready);
    end
    step();
    free_vld = '0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || fl_count !== CW'(2)) begin
      errors++;
      $display("FAIL wrap_after_free: got rdy=%b cnt=%0d required 1 2", in_ready, fl_count);
    end
    step();
    clear_in();
    checks++;
    if (out_dst_preg[0] !== 6'd63 || out_dst_preg[1] !== 6'd9 || fl_count !== CW'(0)) begin
      errors++;
      $display("FAIL wrap_order: got dst=%0d,%0d cnt=%0d required 63,9 0",
               out_dst_preg[0], out_dst_preg[1], fl_count);
    end
  endtask

  task automatic test_reset_collision();
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_lane(0, 1'b1, 1'b1, 0, 3, 4);
    set_lane(1, 1'b0, 1'b0, 0, 0, 0);
    free_vld     = 2'b11;
    free_preg[0] = 6'd20;
    free_preg[1] = 6'd21;
    #1;
    checks++;
    if (rat_w_en !== '0) begin
      errors++;
      $display("FAIL collide_wen: got %b required 00", rat_w_en);
    end
    step();
    rst = 1'b0;
    clear_in();
    checks++;
    if (out_valid !== 1'b0 || fl_count !== CW'(32) || {out_src_preg, out_dst_preg, out_old_preg,
                                                       out_dst_vld, out_lane_vld} !== '0) begin
      errors++;
      $display("FAIL collide_state: got v=%b cnt=%0d lv=%b required 0 32 00",
               out_valid, fl_count, out_lane_vld);
    end
    in_valid = 1'b1;
    set_lane(0, 1'b1, 1'b1, 4, 0, 0);
    step();
    clear_in();
    checks++;
    if (out_dst_preg[0] !== 6'd32 || out_old_preg[0] !== 6'd4) begin
      errors++;
      $display("FAIL collide_first_alloc: got dst=%0d old=%0d required 32 4",
               out_dst_preg[0], out_old_preg[0]);
    end
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    clear_in();
    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending beats required 0", sb.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    clear_in();
    test_reset();
    test_basic();
    test_same_dst();
    test_zero_areg();
    test_stall();
    test_wrap();
    test_reset_collision();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
